// File: rtl/uidbufirq_mc.sv
// uidbufirq_mc: AXI-Lite multi-channel interrupt, coalescing and buffer-status controller
module uidbufirq_mc #(
    parameter int CH_NUM    = 4,
    parameter int BUF_BITS  = 8,
    parameter int COAL_BITS = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [5:0]            S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [5:0]            S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    input  logic [CH_NUM-1:0]     ev_irq,
    input  logic [CH_NUM*8-1:0]   ev_buf,
    output logic                  irq_o
);
    logic                  aw_ready_q, aw_ready_d, b_valid_q, b_valid_d;
    logic                  ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
    logic [31:0]           r_data_q, r_data_d, rd_word;
    logic                  gen_q, gen_d, irq_q, irq_d;
    logic [CH_NUM-1:0]     en_q, en_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [CH_NUM-1:0]     hit, pend_clr, ovf_clr;
    logic [COAL_BITS-1:0]  coal_q, coal_d;
    logic [COAL_BITS:0]    thr;
    logic [BUF_BITS-1:0]   buf_q [CH_NUM];
    logic [BUF_BITS-1:0]   buf_d [CH_NUM];
    logic [7:0]            evc_q [CH_NUM];
    logic [7:0]            evc_d [CH_NUM];
    logic [COAL_BITS-1:0]  cnt_q [CH_NUM];
    logic [COAL_BITS-1:0]  cnt_d [CH_NUM];
    logic                  wr_hs, rd_hs, coal_wr, en_wr;
    logic [3:0]            wa, ra;
    logic                  unused_in;

    assign unused_in = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_WSTRB, S_AXI_WDATA, ev_buf};

    assign wa      = S_AXI_AWADDR[5:2];
    assign ra      = S_AXI_ARADDR[5:2];
    assign wr_hs   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs   = ar_ready_q & S_AXI_ARVALID;
    assign coal_wr = wr_hs && wa == 4'h4;
    assign en_wr   = wr_hs && wa == 4'h1;

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = r_data_q;
    assign irq_o         = irq_q;

    // Ready flags are single-cycle pulses; an outstanding response blocks the next accept.
    always_comb begin
        aw_ready_d = ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q;
        b_valid_d  = wr_hs | (b_valid_q & ~S_AXI_BREADY);
        ar_ready_d = ~ar_ready_q & S_AXI_ARVALID & ~r_valid_q;
        r_valid_d  = rd_hs | (r_valid_q & ~S_AXI_RREADY);
        r_data_d   = rd_hs ? rd_word : r_data_q;
    end

    always_comb begin
        rd_word = '0;
        case (ra)
            4'h0: rd_word[0] = gen_q;
            4'h1: rd_word[CH_NUM-1:0] = en_q;
            4'h2: rd_word[CH_NUM-1:0] = pend_q;
            4'h3: rd_word[CH_NUM-1:0] = ovf_q;
            4'h4: rd_word[COAL_BITS-1:0] = coal_q;
            default: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (ra == 4'(8 + i)) begin
                        rd_word[BUF_BITS-1:0] = buf_q[i];
                        rd_word[23:16]        = evc_q[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        thr      = (coal_q == '0) ? (COAL_BITS+1)'(1) : {1'b0, coal_q};
        pend_clr = (wr_hs && wa == 4'h2) ? S_AXI_WDATA[CH_NUM-1:0] : '0;
        ovf_clr  = (wr_hs && wa == 4'h3) ? S_AXI_WDATA[CH_NUM-1:0] : '0;
        gen_d    = (wr_hs && wa == 4'h0) ? S_AXI_WDATA[0] : gen_q;
        en_d     = en_wr ? S_AXI_WDATA[CH_NUM-1:0] : en_q;
        coal_d   = coal_wr ? S_AXI_WDATA[COAL_BITS-1:0] : coal_q;
        hit      = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            hit[i]   = ev_irq[i] & en_q[i] & (({1'b0, cnt_q[i]} + (COAL_BITS+1)'(1)) >= thr);
            buf_d[i] = ev_irq[i] ? ev_buf[8*i +: BUF_BITS] : buf_q[i];
            evc_d[i] = evc_q[i] + {7'd0, ev_irq[i]};
            cnt_d[i] = (coal_wr || (en_wr && !S_AXI_WDATA[i])) ? '0 :
                       (ev_irq[i] & en_q[i]) ? (hit[i] ? '0 : cnt_q[i] + COAL_BITS'(1)) : cnt_q[i];
        end
        // A new set beats a same-cycle clear; overflow only counts sets onto an uncleared pending bit.
        pend_d = hit | (pend_q & ~pend_clr);
        ovf_d  = (hit & pend_q & ~pend_clr) | (ovf_q & ~ovf_clr);
        irq_d  = gen_q & |(pend_q & en_q);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            gen_q      <= 1'b0;
            en_q       <= '0;
            pend_q     <= '0;
            ovf_q      <= '0;
            coal_q     <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                buf_q[i] <= '0;
                evc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            aw_ready_q <= aw_ready_d;
            b_valid_q  <= b_valid_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            gen_q      <= gen_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            coal_q     <= coal_d;
            irq_q      <= irq_d;
            for (int i = 0; i < CH_NUM; i++) begin
                buf_q[i] <= buf_d[i];
                evc_q[i] <= evc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_uidbufirq_mc.sv
// tb_uidbufirq_mc: randomized and directed bench for uidbufirq_mc against a behavioural model
module tb_uidbufirq_mc;
    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  ev_irq = '0;
    logic [31:0] ev_buf = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    uidbufirq_mc dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ev_irq(ev_irq), .ev_buf(ev_buf), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: spec-level register view, updated once per cycle
    bit          m_gen, m_irq;
    logic [3:0]  m_en, m_pend, m_ovf;
    int          m_coal;
    int          m_cnt [CH];
    int          m_ev  [CH];
    int          m_buf [CH];
    bit          rd_due, wr_due;
    logic [31:0] exp_r;

    function automatic logic [31:0] mread(input logic [5:0] a);
        int k;
        k = int'(a[5:2]);
        if (k == 0) return {31'd0, m_gen};
        if (k == 1) return {28'd0, m_en};
        if (k == 2) return {28'd0, m_pend};
        if (k == 3) return {28'd0, m_ovf};
        if (k == 4) return 32'(m_coal);
        if (k >= 8 && k < 8 + CH) return 32'((m_ev[k-8] << 16) | m_buf[k-8]);
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_gen = 0; m_irq = 0; m_en = 0; m_pend = 0; m_ovf = 0; m_coal = 0;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_ev[i] = 0; m_buf[i] = 0;
        end
        rd_due = 0; wr_due = 0;
    endtask

    task automatic model_step();
        bit          wr, rd, nirq;
        logic [3:0]  wa, clr_p, clr_o, set_p, set_o;
        logic [31:0] wd;
        int          thr;
        wr = awready && awvalid && wvalid;
        rd = arready && arvalid;
        wa = awaddr[5:2];
        wd = wdata;
        if (rd) begin
            exp_r  = mread(araddr);
            rd_due = 1;
        end
        wr_due = wr;
        nirq  = m_gen && ((m_pend & m_en) != 0);
        clr_p = (wr && wa == 2) ? wd[3:0] : 4'd0;
        clr_o = (wr && wa == 3) ? wd[3:0] : 4'd0;
        set_p = 0;
        thr   = (m_coal == 0) ? 1 : m_coal;
        for (int i = 0; i < CH; i++) begin
            if (ev_irq[i]) begin
                m_buf[i] = int'(ev_buf[8*i +: 8]);
                m_ev[i]  = (m_ev[i] + 1) % 256;
                if (m_en[i]) begin
                    if (m_cnt[i] + 1 >= thr) begin
                        m_cnt[i] = 0;
                        set_p[i] = 1;
                    end else m_cnt[i]++;
                end
            end
        end
        set_o  = set_p & m_pend & ~clr_p;
        m_pend = (m_pend & ~clr_p) | set_p;
        m_ovf  = (m_ovf & ~clr_o) | set_o;
        if (wr && wa == 0) m_gen = wd[0];
        if (wr && wa == 1) begin
            for (int i = 0; i < CH; i++) if (!wd[i]) m_cnt[i] = 0;
            m_en = wd[3:0];
        end
        if (wr && wa == 4) begin
            m_coal = int'(wd[3:0]);
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end
        m_irq = nirq;
    endtask

    // Compare process: checks outputs against the model mid-cycle, then advances the model
    initial forever begin
        @(negedge clk);
        if (!rst_n) model_reset();
        chk("irq_o", {31'd0, irq}, {31'd0, m_irq});
        if (rd_due) begin
            chk("rvalid", {31'd0, rvalid}, 32'd1);
            chk("rdata", rdata, exp_r);
            chk("rresp", {30'd0, rresp}, 32'd0);
            rd_due = 0;
        end
        if (wr_due) begin
            chk("bvalid", {31'd0, bvalid}, 32'd1);
            chk("bresp", {30'd0, bresp}, 32'd0);
            wr_due = 0;
        end
        if (rst_n) model_step();
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] evm);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
        while (!awready && n < 20) begin
            @(posedge clk); #2; n++;
        end
        chk("awready", {31'd0, awready}, 32'd1);
        if (evm != 0) ev_irq = evm;
        @(posedge clk); #2;
        if (evm != 0) ev_irq = 0;
        awvalid = 0; wvalid = 0;
        @(posedge clk); #2;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1;
        while (!arready && n < 20) begin
            @(posedge clk); #2; n++;
        end
        chk("arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #2;
        arvalid = 0;
        d = rdata;
        @(posedge clk); #2;
    endtask

    task automatic pulse(input int ch);
        ev_irq[ch] = 1;
        @(posedge clk); #2;
        ev_irq = 0;
        @(posedge clk); #2;
    endtask

    logic [31:0] d;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {30'd0, awready, arready}, 32'd0);
        chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            axi_read(6'(a * 4), d);
            chk("rst_read", d, 32'd0);
        end

        axi_write(6'h04, 32'h1, 4'h0);
        axi_write(6'h00, 32'h1, 4'h0);
        axi_write(6'h10, 32'h0, 4'h0);
        ev_buf = 32'h0000_0005;
        ev_irq = 4'h1;
        @(posedge clk); #2;
        ev_irq = 0;
        chk("irq_t1", {31'd0, irq}, 32'd0);
        @(posedge clk); #2;
        chk("irq_t2", {31'd0, irq}, 32'd1);
        axi_read(6'h08, d);
        chk("pend_ch0", d, 32'h1);
        axi_read(6'h20, d);
        chk("buf0", d, 32'h0001_0005);
        axi_write(6'h08, 32'h1, 4'h0);
        chk("irq_w1c", {31'd0, irq}, 32'd0);

        axi_write(6'h10, 32'd3, 4'h0);
        axi_write(6'h04, 32'h4, 4'h0);
        pulse(2); pulse(2);
        axi_read(6'h08, d);
        chk("coal_2ev", d, 32'h0);
        pulse(2);
        axi_read(6'h08, d);
        chk("coal_3ev", d, 32'h4);
        pulse(2); pulse(2); pulse(2);
        axi_read(6'h0C, d);
        chk("ovf_ch2", d, 32'h4);

        axi_write(6'h0C, 32'hF, 4'h0);
        axi_write(6'h08, 32'hF, 4'h0);
        axi_write(6'h10, 32'd1, 4'h0);
        axi_write(6'h04, 32'h2, 4'h0);
        pulse(1);
        axi_read(6'h08, d);
        chk("pend_ch1", d, 32'h2);
        axi_write(6'h08, 32'h2, 4'h2);
        axi_read(6'h08, d);
        chk("set_wins", d, 32'h2);
        axi_read(6'h0C, d);
        chk("no_ovf", d, 32'h0);

        axi_write(6'h04, 32'h0, 4'h0);
        axi_write(6'h08, 32'hF, 4'h0);
        ev_buf = 32'hA700_0000;
        ev_irq = 4'h8;
        repeat (300) begin
            @(posedge clk); #2;
        end
        ev_irq = 0;
        axi_read(6'h08, d);
        chk("dis_pend", d, 32'h0);
        axi_read(6'h2C, d);
        chk("buf3_cnt", d, 32'h002C_00A7);

        fork
            begin
                repeat (1500) begin
                    ev_irq = 4'($urandom & $urandom);
                    ev_buf = $urandom;
                    @(posedge clk); #2;
                end
                ev_irq = 0;
            end
            begin
                repeat (150) begin
                    int ai;
                    logic [31:0] wd;
                    ai = $urandom_range(0, 15);
                    if ($urandom_range(0, 9) < 4) begin
                        wd = $urandom;
                        if (ai == 4) wd = $urandom_range(0, 5);
                        if (ai == 0) wd = 32'($urandom_range(0, 3) != 0);
                        axi_write(6'(ai * 4), wd, 4'h0);
                    end else axi_read(6'(ai * 4), d);
                end
            end
        join

        axi_write(6'h00, 32'h1, 4'h0);
        bready = 0;
        awaddr = 6'h04; wdata = 32'hF; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 20 && !awready; n++) begin
            @(posedge clk); #2;
        end
        chk("hold_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #2;
        awaddr = 6'h10; wdata = 32'h5;
        repeat (5) begin
            @(posedge clk); #2;
            chk("b_hold", {31'd0, bvalid}, 32'd1);
            chk("aw_block", {31'd0, awready}, 32'd0);
        end
        rst_n = 0;
        #1;
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_irq2", {31'd0, irq}, 32'd0);
        chk("rst_aw2", {31'd0, awready}, 32'd0);
        chk("rst_rdata2", rdata, 32'd0);
        awvalid = 0; wvalid = 0; bready = 1;
        @(posedge clk); #2;
        rst_n = 1;
        for (int a = 0; a < 16; a++) begin
            axi_read(6'(a * 4), d);
            chk("post_rst_read", d, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
